// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Purpose : Bundles every signal between the memory-port arbiter, its two
//           requesters (CPU and DMA/program loader) and the on-chip RAM port.
//
// Signals :
//   cpu_req/cpu_cmd/cpu_addr/cpu_wdata   CPU request (cmd 00 none, 01 wr, 11 rd)
//   cpu_gnt/cpu_rvalid                   CPU grant pulse and read-data strobe
//   dma_req/dma_cmd/dma_addr/dma_wdata   loader request, same encoding
//   dma_gnt/dma_rvalid                   loader grant pulse and read-data strobe
//   rdata                                shared read data, qualified by *_rvalid
//   mem_cmd/mem_addr/mem_wdata           RAM command, address, write data
//   mem_rdata                            RAM read data (one cycle after read cmd)
//   busy                                 arbiter FSM not idle
//
// Modports:
//   slave  : the arbiter itself
//   master : the environment (requesters + RAM) driving the arbiter
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);

  logic              cpu_req;
  logic [1:0]        cpu_cmd;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;

  logic              dma_req;
  logic [1:0]        dma_cmd;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;

  logic [DATA_W-1:0] rdata;

  logic [1:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  cpu_req, cpu_cmd, cpu_addr, cpu_wdata,
    input  dma_req, dma_cmd, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid,
    output rdata, mem_cmd, mem_addr, mem_wdata, busy
  );

  modport master (
    output cpu_req, cpu_cmd, cpu_addr, cpu_wdata,
    output dma_req, dma_cmd, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid,
    input  rdata, mem_cmd, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose : Shares the single RAM read/write port between the CPU path
//           (requester 0) and the DMA/program-loader engine (requester 1).
//           Accesses are serialised through an IDLE -> ISSUE [-> RDATA] FSM,
//           so two RAM commands are never issued in consecutive cycles.
//
// Ports   :
//   clk    system clock, all state changes on its rising edge
//   reset  synchronous, active-low reset (reset==0 resets the block)
//   bus    mem_port_arbiter_if.slave - requester handshakes, RAM port, busy
//
// Timing  : request sampled in IDLE at edge N -> gnt during cycle N+1 (ISSUE,
//           RAM command on the port) -> rvalid/rdata during cycle N+2 (RDATA).
//
// Build option:
//   MEM_ARB_CPU_PRIORITY_EN  defined   : fixed priority, CPU wins every tie
//                            undefined : round-robin on last_owner (default)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_RDATA = 2'b10
  } state_t;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_WR   = 2'b01;
  localparam logic [1:0] CMD_ILL  = 2'b10;
  localparam logic [1:0] CMD_RD   = 2'b11;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_owner;
  logic              r_last_owner;
  logic [1:0]        r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_any_req;
  logic              w_pick_dma;
  logic              w_load;
  logic              w_cmd_real;
  logic [1:0]        w_win_cmd;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;

  assign w_any_req = bus.cpu_req | bus.dma_req;

`ifdef MEM_ARB_CPU_PRIORITY_EN
  // Fixed priority: DMA only wins when the CPU is not asking at all.
  assign w_pick_dma = bus.dma_req & ~bus.cpu_req;
`else
  // Round-robin: on a tie the requester that did not own the last access wins.
  // last_owner resets to DMA so the CPU takes the first tie after reset.
  assign w_pick_dma = bus.dma_req & (~bus.cpu_req | (r_last_owner == OWN_CPU));
`endif

  assign w_win_cmd   = w_pick_dma ? bus.dma_cmd   : bus.cpu_cmd;
  assign w_win_addr  = w_pick_dma ? bus.dma_addr  : bus.cpu_addr;
  assign w_win_wdata = w_pick_dma ? bus.dma_wdata : bus.cpu_wdata;

  // Only write and read reach the RAM; none/illegal are granted as no-ops.
  assign w_cmd_real = (r_cmd != CMD_NONE) && (r_cmd != CMD_ILL);

  // State register and the captured winning request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_CPU;
      r_last_owner <= OWN_DMA;
      r_cmd        <= CMD_NONE;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_owner      <= w_pick_dma;
        r_last_owner <= w_pick_dma;
        r_cmd        <= w_win_cmd;
        r_addr       <= w_win_addr;
        r_wdata      <= w_win_wdata;
      end
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_load         = 1'b0;
    bus.cpu_gnt    = 1'b0;
    bus.dma_gnt    = 1'b0;
    bus.cpu_rvalid = 1'b0;
    bus.dma_rvalid = 1'b0;
    bus.mem_cmd    = CMD_NONE;
    bus.rdata      = '0;

    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_load      = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        bus.cpu_gnt = (r_owner == OWN_CPU);
        bus.dma_gnt = (r_owner == OWN_DMA);
        if (w_cmd_real) begin
          bus.mem_cmd = r_cmd;
        end
        w_state_nxt = (r_cmd == CMD_RD) ? S_RDATA : S_IDLE;
      end
      S_RDATA: begin
        bus.cpu_rvalid = (r_owner == OWN_CPU);
        bus.dma_rvalid = (r_owner == OWN_DMA);
        bus.rdata      = bus.mem_rdata;
        w_state_nxt    = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // A reset that lands in the middle of an access silences its strobes in
    // that same cycle; the access is abandoned and must be re-requested.
    if (!reset) begin
      bus.cpu_gnt    = 1'b0;
      bus.dma_gnt    = 1'b0;
      bus.cpu_rvalid = 1'b0;
      bus.dma_rvalid = 1'b0;
      bus.mem_cmd    = CMD_NONE;
      bus.rdata      = '0;
    end
  end

  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.busy      = (r_state != S_IDLE);

endmodule
